// File: rtl/led_rec_pkg.sv
// Shared constants and the event record layout for the LED event recorder.
package led_rec_pkg;
    localparam int LED_W_DEF = 5;
    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 8;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [LED_W_DEF-1:0] leds;
    } led_event_t;
endpackage

// File: rtl/led_event_recorder_if.sv
// Event drain handshake: producer presents {timestamp, leds}, consumer acks with ready.
interface led_event_recorder_if #(parameter int W = 21) ();
    logic [W-1:0] ev_data;
    logic         ev_valid;
    logic         ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/led_rec_fifo.sv
// Show-ahead FIFO; head output holds its last shown value while empty (0 after reset).
module led_rec_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  last_q;
    logic          wr_en, rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!empty) last_q <= mem[rd_ptr];
        end
    end
endmodule

// File: rtl/led_event_recorder.sv
// Timestamps every change on the LED lines into a FIFO drained over valid/ready.
// Optional: define LED_REC_SYNC_EN to put a 2-flop synchronizer on led_in.
module led_event_recorder
    import led_rec_pkg::*;
#(
    parameter int LED_W = LED_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LED_W-1:0]      led_in,
    led_event_recorder_if.master  ev,
    output logic                  overflow,
    output logic [7:0]            drop_cnt,
    input  logic                  clr_ovf
);
    localparam int EW = TS_W + LED_W;

    logic [TS_W-1:0]        ts;
    logic [LED_W-1:0]       led_prev, led_cmp;
    logic                   change, pop, drop, full, empty;
    logic [EW-1:0]          head;
    logic [$clog2(DEPTH):0] count;

`ifdef LED_REC_SYNC_EN
    logic [LED_W-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= led_in;
            sync2 <= sync1;
        end
    end
    assign led_cmp = sync2;
`else
    assign led_cmp = led_in;
`endif

    assign change = (led_cmp != led_prev);
    assign pop    = ev.ev_valid && ev.ev_ready;
    assign drop   = change && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            led_prev <= '0;
        end else begin
            ts       <= ts + 1'b1;
            led_prev <= led_cmp;
        end
    end

    // Clear beats a simultaneous drop.
    always_ff @(posedge clk) begin
        if (rst || clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    led_rec_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .din   ({ts, led_cmp}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign ev.ev_data  = head;
    assign ev.ev_valid = !empty;
endmodule

// File: tb/tb_led_event_recorder.sv
// Randomized and directed bench for led_event_recorder against a queue-based reference model.
module tb_led_event_recorder;
    import led_rec_pkg::*;

    localparam int LW = 5;
    localparam int TW = 16;
    localparam int D  = 8;
    localparam int EW = TW + LW;

    logic          clk = 1'b0;
    logic          rst, clr_ovf;
    logic [LW-1:0] led_in;
    logic          overflow;
    logic [7:0]    drop_cnt;

    led_event_recorder_if #(.W(EW)) ev ();

    led_event_recorder #(.LED_W(LW), .TS_W(TW), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .led_in   (led_in),
        .ev       (ev),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [TW-1:0] ts_m;
    logic [LW-1:0] prev_m, s1_m, s2_m;
    logic [EW-1:0] q[$];
    logic          ovf_m;
    int            dc_m;
    logic [EW-1:0] last_m;
    int unsigned   since_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [LW-1:0] l, input logic rdy, input logic clr);
        logic [LW-1:0] cmp;
        logic [EW-1:0] exp_data;
        bit            pop, drop;
        int            sz;
        rst = r; led_in = l; ev.ev_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        if (r) begin
            ts_m = '0; prev_m = '0; s1_m = '0; s2_m = '0;
            q.delete(); ovf_m = 1'b0; dc_m = 0; last_m = '0; since_rst = 0;
        end else begin
`ifdef LED_REC_SYNC_EN
            cmp = s2_m; s2_m = s1_m; s1_m = l;
`else
            cmp = l;
`endif
            sz = q.size();
            pop = (sz > 0) && rdy;
            drop = 1'b0;
            if (pop) void'(q.pop_front());
            if (cmp != prev_m) begin
                if (sz < D || pop) q.push_back({ts_m, cmp});
                else drop = 1'b1;
            end
            if (clr) begin
                ovf_m = 1'b0; dc_m = 0;
            end else if (drop) begin
                ovf_m = 1'b1;
                if (dc_m < 255) dc_m++;
            end
            prev_m = cmp;
            ts_m = ts_m + 1'b1;
            since_rst++;
        end
        #1;
        exp_data = (q.size() > 0) ? q[0] : last_m;
        if (q.size() > 0) last_m = q[0];
        chk("ev_valid", 32'(ev.ev_valid), 32'(q.size() > 0));
        chk("ev_data", 32'(ev.ev_data), 32'(exp_data));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("drop_cnt", 32'(drop_cnt), 32'(dc_m));
    endtask

    initial begin
        int unsigned t0;
        logic [LW-1:0] l;
        led_event_t e;
        rst = 1'b1; led_in = '0; ev.ev_ready = 1'b0; clr_ovf = 1'b0;

        // reset state, then a single held value logged once
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_data", 32'(ev.ev_data), 32'd0);
        step(0, 5'b00001, 1, 0);
`ifndef LED_REC_SYNC_EN
        chk("first_ev", 32'(ev.ev_data), 32'({16'd0, 5'b00001}));
        chk("first_vld", 32'(ev.ev_valid), 32'd1);
        step(0, 5'b00001, 1, 0);
        chk("first_vld_drop", 32'(ev.ev_valid), 32'd0);
`endif
        for (int i = 0; i < 6; i++) step(0, 5'b00001, 1, 0);

        // change at ts=10 held while not ready
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 5'b10100, 0, 0);
        for (int i = 0; i < 5; i++) begin
`ifndef LED_REC_SYNC_EN
            e = led_event_t'(ev.ev_data);
            chk("hold_ts", 32'(e.ts), 32'd10);
            chk("hold_leds", 32'(e.leds), 32'(5'b10100));
`endif
            step(0, 5'b10100, 0, 0);
        end
        for (int i = 0; i < 4; i++) step(0, 5'b10100, 1, 0);

        // overflow by toggling LED1, then full+pop+push, drain, clear
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, (i % 2 == 0) ? 5'b00001 : 5'b00000, 0, 0);
`ifndef LED_REC_SYNC_EN
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(drop_cnt), 32'd2);
`endif
        step(0, 5'b00001, 1, 0);
`ifndef LED_REC_SYNC_EN
        chk("fullpop_cnt", 32'(drop_cnt), 32'd2);
        e = led_event_t'(ev.ev_data);
        chk("fullpop_head", 32'(e.ts), 32'd1);
`endif
        for (int i = 0; i < 10; i++) step(0, 5'b00001, 1, 0);
        step(0, 5'b00001, 0, 1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(drop_cnt), 32'd0);

        // drop_cnt saturation
        for (int i = 0; i < 280; i++) step(0, LW'(i), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, i == 9);

        // timestamp wrap: no event at wrap, event ts = edge count mod 2^16
        step(1, 0, 0, 0);
        for (int i = 0; i < 65546; i++) step(0, 0, 1, 0);
        t0 = since_rst;
        step(0, 5'b00011, 0, 0);
`ifndef LED_REC_SYNC_EN
        e = led_event_t'(ev.ev_data);
        chk("wrap_ts", 32'(e.ts), t0 % 65536);
`endif
        for (int i = 0; i < 4; i++) step(0, 5'b00011, 1, 0);

        // reset flushes queued entries
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, (i % 2 == 0) ? 5'b00001 : 5'b00000, 0, 0);
        step(1, 5'b00001, 1, 0);
        chk("flush_vld", 32'(ev.ev_valid), 32'd0);
        step(0, 5'b00110, 0, 0);
`ifndef LED_REC_SYNC_EN
        chk("flush_ev", 32'(ev.ev_data), 32'({16'd0, 5'b00110}));
`endif
        for (int i = 0; i < 4; i++) step(0, 5'b00110, 1, 0);

        // random traffic
        l = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) l = LW'($urandom);
            step($urandom_range(199) == 0, l, 1'($urandom), $urandom_range(49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
